// File: rtl/cva6_fifo_reader_pkg.sv
// Shared frontend definitions for the FIFO pop-side reader.
package cva6_fifo_reader_pkg;

  // Number of entries held locally by the reader (output + skid register).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_rd_state_e;

  // Width of the occupancy report (counts 0..2).
  localparam int unsigned OCC_WIDTH = 2;

  // Map the reader state onto the number of entries it holds.
  function automatic logic [OCC_WIDTH-1:0] occupancy_of(input fifo_rd_state_e st);
    logic [OCC_WIDTH-1:0] occ;
    case (st)
      ONE:     occ = OCC_WIDTH'(1);
      TWO:     occ = OCC_WIDTH'(2);
      default: occ = '0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/cva6_fifo_reader.sv
// Pop-side reader for the frontend FIFO. Drains the FIFO's empty/data/pop
// interface into a registered valid/ready stream using an output register
// plus one skid register, so the pop request never looks at downstream
// ready. Also counts every entry popped, for performance monitoring.
module cva6_fifo_reader
  import cva6_fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  dtype                 fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  output dtype                 data_o,
  input  logic                 ready_i,
  output logic [OCC_WIDTH-1:0] occupancy_o,
  output logic [CNT_WIDTH-1:0] pop_cnt_o
);

  fifo_rd_state_e       st_q;
  dtype                 out_q;
  dtype                 skid_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic pop;
  logic fire;

  // Pop only depends on FIFO state, flush, reset and our own fill level;
  // downstream ready is deliberately excluded so no combinational path
  // runs from ready_i to the FIFO.
  assign pop  = ~fifo_empty_i & ~flush_i & ~rst_i & (st_q != TWO);
  assign fire = valid_o & ready_i;

  assign fifo_pop_o  = pop;
  assign valid_o     = (st_q != EMPTY);
  assign data_o      = out_q;
  assign occupancy_o = occupancy_of(st_q);
  assign pop_cnt_o   = cnt_q;

  // Reader FSM: tracks fill level and moves entries head <- skid <- FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q   <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      // Held entries are simply forgotten; register contents are don't-care.
      st_q <= EMPTY;
    end else begin
      case (st_q)
        EMPTY: begin
          if (pop) begin
            st_q  <= ONE;
            out_q <= fifo_data_i;
          end
        end
        ONE: begin
          if (fire && pop) begin
            out_q <= fifo_data_i;
          end else if (fire) begin
            st_q <= EMPTY;
          end else if (pop) begin
            // Head is stalled; park the younger entry in the skid register.
            st_q   <= TWO;
            skid_q <= fifo_data_i;
          end
        end
        TWO: begin
          // Pop is impossible here, so the skid entry moves up on fire.
          if (fire) begin
            st_q  <= ONE;
            out_q <= skid_q;
          end
        end
        default: st_q <= EMPTY;
      endcase
    end
  end

  // Free-running drained-entry counter; wraps naturally, survives flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cva6_fifo_reader.sv
// Testbench for cva6_fifo_reader: directed phases with randomized traffic,
// checked against a queue-based model of the FIFO and the reader's holdings.
module tb_cva6_fifo_reader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_pop_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        ready_i;
  logic [1:0]  occupancy_o;
  logic [15:0] pop_cnt_o;

  // Narrow-counter instance for the wrap check.
  logic        w_empty;
  logic [31:0] w_data;
  logic        w_pop;
  logic        w_valid;
  logic [31:0] w_dout;
  logic [1:0]  w_occ;
  logic [3:0]  w_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the upstream FIFO and the entries the
  // reader is holding (oldest first), plus the expected pop count.
  logic [31:0] src[$];
  logic [31:0] held[$];
  int unsigned mcnt = 0;

  always #5 clk_i = ~clk_i;

  cva6_fifo_reader #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .fifo_pop_o  (fifo_pop_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .occupancy_o (occupancy_o),
    .pop_cnt_o   (pop_cnt_o)
  );

  cva6_fifo_reader #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_w (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (1'b0),
    .fifo_empty_i(w_empty),
    .fifo_data_i (w_data),
    .fifo_pop_o  (w_pop),
    .valid_o     (w_valid),
    .data_o      (w_dout),
    .ready_i     (1'b1),
    .occupancy_o (w_occ),
    .pop_cnt_o   (w_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: drive inputs at the falling edge, compare against
  // the model, then advance the model across the rising edge.
  task automatic step(input logic rdy, input logic fl);
    logic e_pop;
    logic e_vld;
    @(negedge clk_i);
    ready_i      = rdy;
    flush_i      = fl;
    fifo_empty_i = (src.size() == 0);
    fifo_data_i  = (src.size() != 0) ? src[0] : 32'hDEAD_BEEF;
    #1;
    e_vld = (held.size() != 0);
    e_pop = (src.size() != 0) && !fl && (held.size() < 2);
    chk("pop", fifo_pop_o, e_pop);
    chk("valid", valid_o, e_vld);
    chk("occupancy", occupancy_o, held.size());
    chk("pop_cnt", pop_cnt_o, 16'(mcnt));
    if (e_vld) chk("data", data_o, held[0]);
    @(posedge clk_i);
    if (e_vld && rdy) void'(held.pop_front());
    if (e_pop) begin
      held.push_back(src.pop_front());
      mcnt++;
    end
    if (fl) begin
      held.delete();
      src.delete();
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    ready_i      = 1'b1;
    w_empty      = 1'b1;
    w_data       = 32'h0;
    // Reset with a non-empty FIFO: nothing may be popped while in reset.
    src = '{32'hA, 32'hB, 32'hC};
    fifo_empty_i = 1'b0;
    fifo_data_i  = 32'hA;
    #12;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_occ", occupancy_o, 2'd0);
    chk("rst_pop", fifo_pop_o, 1'b0);
    chk("rst_cnt", pop_cnt_o, 16'h0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Streaming three entries with ready held high.
    repeat (6) step(1'b1, 1'b0);
    #1;
    chk("stream_cnt", pop_cnt_o, 16'd3);
    chk("stream_occ", occupancy_o, 2'd0);

    // Backpressure: only two entries are taken, head stays put.
    src = '{32'h1, 32'h2, 32'h3, 32'h4};
    repeat (4) step(1'b0, 1'b0);
    #1;
    chk("bp_occ", occupancy_o, 2'd2);
    chk("bp_data", data_o, 32'h1);
    chk("bp_pop", fifo_pop_o, 1'b0);
    repeat (7) step(1'b1, 1'b0);

    // Ready toggling every cycle with a FIFO that never runs dry.
    for (int i = 0; i < 40; i++) begin
      while (src.size() < 3) src.push_back($urandom);
      step(1'(i % 2), 1'b0);
    end

    // Flush while full.
    while (src.size() < 4) src.push_back($urandom);
    repeat (3) step(1'b0, 1'b0);
    #1 chk("pre_flush_occ", occupancy_o, 2'd2);
    step(1'($urandom_range(0, 1)), 1'b1);
    #1;
    chk("flush_valid", valid_o, 1'b0);
    chk("flush_occ", occupancy_o, 2'd0);
    chk("flush_cnt", pop_cnt_o, 16'(mcnt));

    // Random mixed traffic with occasional flushes.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) < 6) src.push_back($urandom);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset mid-cycle while one entry is held.
    src.delete();
    repeat (3) step(1'b1, 1'b0);
    src.push_back(32'h55);
    step(1'b0, 1'b0);
    #1 chk("pre_rst_occ", occupancy_o, 2'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_data", data_o, 32'h0);
    chk("arst_cnt", pop_cnt_o, 16'h0);
    chk("arst_occ", occupancy_o, 2'd0);
    held.delete();
    src.delete();
    mcnt = 0;
    fifo_empty_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (2) step(1'b1, 1'b0);

    // Narrow counter wraps after 16 pops.
    @(negedge clk_i);
    w_empty = 1'b0;
    w_data  = 32'h77;
    repeat (16) @(posedge clk_i);
    #1 chk("wrap16_cnt", w_cnt, 4'h0);
    @(posedge clk_i);
    #1 chk("wrap17_cnt", w_cnt, 4'h1);
    @(negedge clk_i) w_empty = 1'b1;
    @(posedge clk_i);
    #1 chk("wrap_hold_cnt", w_cnt, 4'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
